ifetch_ctrl: RTL and testbench

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

---
 rtl/ifetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_ifetch_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: fetches one word per start command,
// holds it in the instruction register until the decoder consumes it,
// then issues a single-cycle PC update with the sequential or redirect target.
module ifetch_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        start,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        ir_ack,
    output logic [31:0] npc,
    output logic        pc_en,
    output logic        busy,
    output logic        fetch_err
);

    localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_UPD,
        S_ERR
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          req_d, irv_d, pc_en_d, busy_d, err_d;
    logic [31:0]   addr_d, ir_d, npc_d;
    logic [31:0]   target;

    // State and every output are registered; next values come from the comb block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            ir        <= '0;
            ir_valid  <= 1'b0;
            npc       <= '0;
            pc_en     <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            imem_req  <= req_d;
            imem_addr <= addr_d;
            ir        <= ir_d;
            ir_valid  <= irv_d;
            npc       <= npc_d;
            pc_en     <= pc_en_d;
            busy      <= busy_d;
            fetch_err <= err_d;
        end
    end

    // Next PC candidate: redirect target or sequential step (wraps at 2^32).
    always_comb begin
        target = redirect ? redirect_pc : (imem_addr + 32'(PC_STEP));
    end

    // Next-state and next-output logic; anything not assigned holds its value.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        req_d   = imem_req;
        addr_d  = imem_addr;
        ir_d    = ir;
        irv_d   = ir_valid;
        npc_d   = npc;
        pc_en_d = 1'b0;
        err_d   = fetch_err;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (pc[1:0] == 2'b00) begin
                        addr_d  = pc;
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_REQ: begin
                if (imem_gnt) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response in the final counted cycle still beats the timeout.
                if (imem_rvalid) begin
                    ir_d    = imem_rdata;
                    irv_d   = 1'b1;
                    state_d = S_HOLD;
                end else if (cnt == CW'(MAX_WAIT)) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (ir_ack) begin
                    irv_d = 1'b0;
                    npc_d = target;
                    if (redirect && (redirect_pc[1:0] != 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        pc_en_d = 1'b1;
                        state_d = S_UPD;
                    end
                end
            end
            S_UPD: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                req_d = 1'b0;
                err_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed fetch sequences push expected IR loads,
// PC updates and fault entries into a queue; a monitor pops and compares
// whenever the DUT presents one of those events.
module tb_ifetch_ctrl;

    localparam int MAXW = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        start;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic        ir_valid;
    logic        ir_ack;
    logic [31:0] npc;
    logic        pc_en;
    logic        busy;
    logic        fetch_err;

    ifetch_ctrl #(.MAX_WAIT(MAXW), .PC_STEP(4)) dut (
        .clk(clk), .rst(rst), .pc(pc), .start(start),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .ir(ir), .ir_valid(ir_valid), .ir_ack(ir_ack),
        .npc(npc), .pc_en(pc_en), .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    localparam int EV_IR  = 0;
    localparam int EV_PC  = 1;
    localparam int EV_ERR = 2;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;

    task automatic push(input int kind, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each presented event against the head of the queue.
    logic irv_q = 1'b0;
    logic err_q = 1'b0;

    task automatic sb(input int kind, input logic [31:0] val);
        exp_t e;
        compared++;
        if (q.size() == 0) begin
            mismatched++;
            $display("FAIL sb_unexpected: got event %0d value %h expected none at %0t", kind, val, $time);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                mismatched++;
                $display("FAIL sb_event: got event %0d value %h expected event %0d value %h at %0t",
                         kind, val, e.kind, e.val, $time);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (ir_valid && !irv_q) sb(EV_IR, ir);
            if (pc_en) sb(EV_PC, npc);
            if (fetch_err && !err_q) sb(EV_ERR, 32'h0);
            irv_q = ir_valid;
            err_q = fetch_err;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_irv", {31'b0, ir_valid}, 32'h0);
        chk("rst_npc", npc, 32'h0);
        chk("rst_pcen", {31'b0, pc_en}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_err", {31'b0, fetch_err}, 32'h0);
        rst = 1'b0;
    endtask

    // One full fetch: gd cycles before grant, rd WAIT cycles before rvalid.
    task automatic fetch(input logic [31:0] p, input int gd, input int rd,
                         input logic [31:0] data, input logic rdr, input logic [31:0] rpc,
                         input logic [31:0] exp_npc, input logic exp_err);
        pc = p;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_req", {31'b0, busy}, 32'h1);
        for (int i = 0; i < gd; i++) begin
            chk("req_hold", {31'b0, imem_req}, 32'h1);
            chk("addr_hold", imem_addr, p);
            tick();
        end
        chk("req_at_gnt", {31'b0, imem_req}, 32'h1);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("req_cleared", {31'b0, imem_req}, 32'h0);
        for (int i = 0; i < rd; i++) tick();
        push(EV_IR, data);
        imem_rvalid = 1'b1;
        imem_rdata = data;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata = 32'hDEADBEEF;
        tick();
        chk("hold_irv", {31'b0, ir_valid}, 32'h1);
        chk("hold_ir", ir, data);
        if (exp_err) push(EV_ERR, 32'h0);
        else push(EV_PC, exp_npc);
        redirect = rdr;
        redirect_pc = rpc;
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        chk("ack_irv", {31'b0, ir_valid}, 32'h0);
        if (!exp_err) begin
            chk("upd_busy", {31'b0, busy}, 32'h1);
            tick();
            chk("idle_busy", {31'b0, busy}, 32'h0);
            chk("idle_pcen", {31'b0, pc_en}, 32'h0);
            chk("npc_held", npc, exp_npc);
        end else begin
            chk("err_flag", {31'b0, fetch_err}, 32'h1);
            tick();
            chk("err_pcen", {31'b0, pc_en}, 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1; pc = 32'h0; start = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; ir_ack = 1'b0;
        tick();
        do_reset();
        tick();

        // Sequential fetch, redirect, wrap-around, latest-possible response.
        fetch(32'h0000_0100, 2, 3, 32'h00A0_0093, 1'b0, 32'h0, 32'h0000_0104, 1'b0);
        fetch(32'h0000_0200, 0, 0, 32'h1111_2222, 1'b1, 32'h0000_0080, 32'h0000_0080, 1'b0);
        fetch(32'hFFFF_FFFC, 1, 1, 32'h3333_4444, 1'b0, 32'h0, 32'h0000_0000, 1'b0);
        fetch(32'h0000_0010, 0, MAXW, 32'h5555_6666, 1'b0, 32'h0, 32'h0000_0014, 1'b0);

        // Misaligned redirect target: fault, no PC update.
        fetch(32'h0000_0040, 0, 2, 32'h7777_8888, 1'b1, 32'h0000_0081, 32'h0, 1'b1);
        do_reset();

        // Misaligned start PC: straight to fault, never requests.
        pc = 32'h0000_0102;
        push(EV_ERR, 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mis_err", {31'b0, fetch_err}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            chk("mis_noreq", {31'b0, imem_req}, 32'h0);
            pc = 32'h0000_0100;
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk("mis_sticky", {31'b0, fetch_err}, 32'h1);
        do_reset();

        // Grant with no response: timeout after MAX_WAIT+1 WAIT cycles.
        pc = 32'h0000_0300;
        start = 1'b1;
        tick();
        start = 1'b0;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        for (int i = 0; i < MAXW; i++) tick();
        chk("to_not_yet", {31'b0, fetch_err}, 32'h0);
        push(EV_ERR, 32'h0);
        tick();
        chk("to_err", {31'b0, fetch_err}, 32'h1);
        chk("to_noreq", {31'b0, imem_req}, 32'h0);
        chk("to_busy", {31'b0, busy}, 32'h1);
        do_reset();

        // Reset during WAIT, stale response afterwards is discarded.
        pc = 32'h0000_0400;
        start = 1'b1;
        tick();
        start = 1'b0;
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
        chk("rw_busy", {31'b0, busy}, 32'h0);
        chk("rw_irv", {31'b0, ir_valid}, 32'h0);
        chk("rw_ir", ir, 32'h0);
        chk("rw_pcen", {31'b0, pc_en}, 32'h0);
        chk("rw_req", {31'b0, imem_req}, 32'h0);
        tick();
        chk("rw_idle", {31'b0, busy}, 32'h0);

        repeat (3) tick();
        chk("sb_drained", q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
